// File: rtl/audio_codec_init_seq_pkg.sv
// Shared types and constants for the audio codec configuration sequencer:
// FSM state encoding, codec I2C address, register map and the default
// register-write table walked by the sequencer.
package audio_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    GAP    = 3'd3,
    FINISH = 3'd4,
    ABORT  = 3'd5
  } cfg_state_t;

  // Codec 8-bit I2C write address (7-bit address 0x1A plus R/W=0).
  localparam logic [7:0] CODEC_DEV_ADDR = 8'h34;

  // Codec register addresses (7-bit).
  localparam logic [6:0] REG_LLINE_IN = 7'h00;
  localparam logic [6:0] REG_RLINE_IN = 7'h01;
  localparam logic [6:0] REG_LHP_OUT  = 7'h02;
  localparam logic [6:0] REG_RHP_OUT  = 7'h03;
  localparam logic [6:0] REG_APATH    = 7'h04;
  localparam logic [6:0] REG_DPATH    = 7'h05;
  localparam logic [6:0] REG_POWER    = 7'h06;
  localparam logic [6:0] REG_DAIF     = 7'h07;
  localparam logic [6:0] REG_SRATE    = 7'h08;
  localparam logic [6:0] REG_ACTIVE   = 7'h09;
  localparam logic [6:0] REG_RESET    = 7'h0F;

  // Packs one table entry as {reg[6:0], data[8:0]}.
  function automatic logic [15:0] cfg_word(input logic [6:0] reg_addr,
                                           input logic [8:0] data);
    return {reg_addr, data};
  endfunction

  // Default 16-entry table; index 0 is the leftmost element.
  localparam logic [0:15][15:0] CODEC_CFG_TABLE = {
    cfg_word(REG_RESET,    9'h000),  // codec reset
    cfg_word(REG_POWER,    9'h000),  // power everything on
    cfg_word(REG_LLINE_IN, 9'h017),  // left line in
    cfg_word(REG_RLINE_IN, 9'h017),  // right line in
    cfg_word(REG_LHP_OUT,  9'h079),  // left headphone
    cfg_word(REG_RHP_OUT,  9'h079),  // right headphone
    cfg_word(REG_APATH,    9'h012),  // analog path
    cfg_word(REG_DPATH,    9'h000),  // digital path
    cfg_word(REG_DAIF,     9'h001),  // left-justified, 16-bit
    cfg_word(REG_SRATE,    9'h000),  // normal mode, 48 kHz
    cfg_word(REG_ACTIVE,   9'h001),  // activate interface
    16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000
  };

endpackage

// File: rtl/audio_codec_init_seq_if.sv
// Sequencer <-> I2C write-only transmitter handshake.
// master = configuration sequencer, slave = transmitter.
// i2c_fail is only meaningful in the cycle i2c_done_tick is high.
interface audio_codec_init_seq_if;
  logic [23:0] din;
  logic        wr_i2c;
  logic        i2c_idle;
  logic        i2c_done_tick;
  logic        i2c_fail;

  modport master (output din, wr_i2c, input i2c_idle, i2c_done_tick, i2c_fail);
  modport slave  (input din, wr_i2c, output i2c_idle, i2c_done_tick, i2c_fail);
endinterface

// File: rtl/audio_codec_init_seq_cfg_rom.sv
// Purpose: combinational index -> {reg, data} lookup of the codec write table.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the sequencer samples the entry when it issues a write.
module codec_cfg_rom
  import audio_cfg_pkg::*;
#(
  parameter logic [0:15][15:0] TABLE = CODEC_CFG_TABLE
) (
  input  logic [3:0]  idx,
  output logic [15:0] entry
);

  assign entry = TABLE[idx];

endmodule

// File: rtl/audio_codec_init_seq.sv
// Purpose: walks the codec register table, one I2C write per entry, with retry/abort.
// Latency: wr_i2c one clock after ISSUE sees i2c_idle; done_tick one clock after FINISH/ABORT.
// Backpressure: stalls in ISSUE while i2c_idle=0; start is ignored while a run is busy.
module audio_codec_init_seq
  import audio_cfg_pkg::*;
#(
  parameter int         NUM_REGS   = 11,
  parameter logic [7:0] DEV_ADDR   = CODEC_DEV_ADDR,
  parameter int         MAX_RETRY  = 3,
  parameter int         GAP_CYCLES = 500,
  parameter int         TIMEOUT    = 65535
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  audio_codec_init_seq_if.master        i2c,
  output logic                          busy,
  output logic                          done_tick,
  output logic                          cfg_ok,
  output logic                          cfg_err,
  output logic [3:0]                    err_idx
);

  localparam logic [3:0]  LAST_IDX = 4'(NUM_REGS - 1);
  localparam logic [2:0]  RETRY_LIM = 3'(MAX_RETRY);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

  cfg_state_t  state_q, state_n;
  logic [3:0]  idx_q, idx_n;
  logic [2:0]  retry_q, retry_n, retry_inc;
  logic [15:0] gap_cnt_q, gap_cnt_n;
  logic [15:0] to_cnt_q, to_cnt_n;
  logic [23:0] din_q, din_n;
  logic        wr_q, wr_n;
  logic        busy_q, busy_n;
  logic        done_q, done_n;
  logic        ok_q, ok_n;
  logic        err_q, err_n;
  logic [3:0]  err_idx_q, err_idx_n;
  logic [15:0] rom_entry;
  logic        attempt_ok, attempt_bad;

  codec_cfg_rom u_rom (
    .idx   (idx_q),
    .entry (rom_entry)
  );

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_n     = state_q;
    idx_n       = idx_q;
    retry_n     = retry_q;
    gap_cnt_n   = gap_cnt_q;
    to_cnt_n    = to_cnt_q;
    din_n       = din_q;
    wr_n        = 1'b0;
    busy_n      = busy_q;
    done_n      = 1'b0;
    ok_n        = ok_q;
    err_n       = err_q;
    err_idx_n   = err_idx_q;
    retry_inc   = (retry_q == 3'd7) ? retry_q : retry_q + 3'd1;
    // A completion pulse wins over a coincident timeout.
    attempt_ok  = i2c.i2c_done_tick && !i2c.i2c_fail;
    attempt_bad = i2c.i2c_done_tick ? i2c.i2c_fail : (to_cnt_q == TO_LAST);

    case (state_q)
      IDLE: begin
        if (start) begin
          idx_n   = 4'd0;
          retry_n = 3'd0;
          ok_n    = 1'b0;
          err_n   = 1'b0;
          busy_n  = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (i2c.i2c_idle) begin
          wr_n     = 1'b1;
          din_n    = {DEV_ADDR, rom_entry};
          to_cnt_n = 16'd0;
          state_n  = WAIT;
        end
      end
      WAIT: begin
        to_cnt_n = (to_cnt_q == 16'hFFFF) ? to_cnt_q : to_cnt_q + 16'd1;
        if (attempt_ok) begin
          if (idx_q == LAST_IDX) begin
            state_n = FINISH;
          end else begin
            idx_n     = idx_q + 4'd1;
            retry_n   = 3'd0;
            gap_cnt_n = 16'd0;
            state_n   = GAP;
          end
        end else if (attempt_bad) begin
          retry_n = retry_inc;
          if (retry_inc == RETRY_LIM) begin
            err_idx_n = idx_q;
            state_n   = ABORT;
          end else begin
            gap_cnt_n = 16'd0;
            state_n   = GAP;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q >= GAP_LAST) begin
          state_n = ISSUE;
        end else begin
          gap_cnt_n = gap_cnt_q + 16'd1;
        end
      end
      FINISH: begin
        ok_n    = 1'b1;
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      ABORT: begin
        err_n   = 1'b1;
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counters and registered outputs; reset abandons any run at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= 4'd0;
      retry_q   <= 3'd0;
      gap_cnt_q <= 16'd0;
      to_cnt_q  <= 16'd0;
      din_q     <= 24'd0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      err_idx_q <= 4'd0;
    end else begin
      state_q   <= state_n;
      idx_q     <= idx_n;
      retry_q   <= retry_n;
      gap_cnt_q <= gap_cnt_n;
      to_cnt_q  <= to_cnt_n;
      din_q     <= din_n;
      wr_q      <= wr_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
      ok_q      <= ok_n;
      err_q     <= err_n;
      err_idx_q <= err_idx_n;
    end
  end

  assign i2c.din    = din_q;
  assign i2c.wr_i2c = wr_q;
  assign busy       = busy_q;
  assign done_tick  = done_q;
  assign cfg_ok     = ok_q;
  assign cfg_err    = err_q;
  assign err_idx    = err_idx_q;

endmodule

// File: tb/tb_audio_codec_init_seq.sv
// Directed bench for audio_codec_init_seq with a behavioural I2C transmitter
// that ACKs, NACKs selected frames or never answers, logging every write.
module tb_audio_codec_init_seq;
  import audio_cfg_pkg::*;

  localparam int GAP = 500;
  localparam int TO  = 100;
  localparam int LAT = 4;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       busy, done_tick, cfg_ok, cfg_err;
  logic [3:0] err_idx;

  int checks   = 0;
  int failures = 0;

  // Transmitter model controls and logs.
  logic        hold_low  = 1'b0;
  logic        no_resp   = 1'b0;
  logic [23:0] nack_din  = 24'h0;
  int          nack_left = 0;   // -1 = NACK forever
  logic        active    = 1'b0;
  int          pending   = 0;
  logic [23:0] cur_din   = 24'h0;
  logic [23:0] wr_log[$];
  int          wr_cyc[$];
  int          done_cyc[$];
  int          cyc = 0;

  logic [23:0] exp_tab [11] = '{24'h341E00, 24'h340C00, 24'h340017, 24'h340217,
                                24'h340479, 24'h340679, 24'h340812, 24'h340A00,
                                24'h340E01, 24'h341000, 24'h341201};

  audio_codec_init_seq_if bus ();

  audio_codec_init_seq #(
    .NUM_REGS   (11),
    .DEV_ADDR   (8'h34),
    .MAX_RETRY  (3),
    .GAP_CYCLES (GAP),
    .TIMEOUT    (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .i2c       (bus.master),
    .busy      (busy),
    .done_tick (done_tick),
    .cfg_ok    (cfg_ok),
    .cfg_err   (cfg_err),
    .err_idx   (err_idx)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model, evaluated mid-cycle so the DUT samples stable inputs.
  always @(negedge clk) begin
    bus.i2c_done_tick = 1'b0;
    bus.i2c_fail      = 1'b0;
    if (reset) begin
      active  = 1'b0;
      pending = 0;
    end else if (bus.wr_i2c) begin
      wr_log.push_back(bus.din);
      wr_cyc.push_back(cyc);
      cur_din = bus.din;
      active  = 1'b1;
      pending = LAT;
    end else if (active && !no_resp) begin
      pending--;
      if (pending == 0) begin
        active = 1'b0;
        bus.i2c_done_tick = 1'b1;
        if (cur_din == nack_din && nack_left != 0) begin
          bus.i2c_fail = 1'b1;
          if (nack_left > 0) nack_left--;
        end
        done_cyc.push_back(cyc);
      end
    end
    bus.i2c_idle = !hold_low && (!active || no_resp);
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset     = 1'b1;
    hold_low  = 1'b0;
    no_resp   = 1'b0;
    nack_din  = 24'h0;
    nack_left = 0;
    repeat (3) @(posedge clk);
    #1;
    wr_log.delete();
    wr_cyc.delete();
    done_cyc.delete();
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while (done_tick !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done_tick !== 1'b1) begin
      failures++;
      $display("FAIL %s_timeout done_tick=%b required=1 within %0d cycles", name, done_tick, budget);
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1 reset = 1'b1;
    #1;
    checks++; if (bus.din !== 24'h0) begin failures++; $display("FAIL reset_din got=%h exp=000000", bus.din); end
    checks++; if (bus.wr_i2c !== 1'b0) begin failures++; $display("FAIL reset_wr got=%b exp=0", bus.wr_i2c); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done_tick !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done_tick); end
    checks++; if ({cfg_ok, cfg_err} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {cfg_ok, cfg_err}); end
    checks++; if (err_idx !== 4'd0) begin failures++; $display("FAIL reset_err_idx got=%0d exp=0", err_idx); end
    do_reset();
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b0 || wr_log.size() != 0) begin failures++; $display("FAIL idle_quiet busy=%b writes=%0d exp 0/0", busy, wr_log.size()); end
  endtask

  task automatic test_all_ack();
    do_reset();
    pulse_start();
    wait_done(20000, "all_ack");
    checks++; if (wr_log.size() != 11) begin failures++; $display("FAIL all_ack_count got=%0d exp=11", wr_log.size()); end
    checks++; if (cfg_ok !== 1'b1 || cfg_err !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL all_ack_status ok/err/busy=%b%b%b exp=100", cfg_ok, cfg_err, busy); end
    if (wr_log.size() == 11) begin
      for (int i = 0; i < 11; i++) begin
        checks++; if (wr_log[i] !== exp_tab[i]) begin failures++; $display("FAIL all_ack_din[%0d] got=%h exp=%h", i, wr_log[i], exp_tab[i]); end
      end
      // done seen at cycle P: GAP holds P+1..P+500, ISSUE at P+501, wr_i2c at P+502.
      for (int i = 1; i < 11; i++) begin
        if (done_cyc.size() >= i) begin
          checks++; if (wr_cyc[i] - done_cyc[i-1] != GAP + 2) begin failures++; $display("FAIL all_ack_gap[%0d] got=%0d exp=%0d", i, wr_cyc[i] - done_cyc[i-1], GAP + 2); end
        end
      end
    end
    @(negedge clk);
    checks++; if (done_tick !== 1'b0) begin failures++; $display("FAIL done_pulse_width got=%b exp=0", done_tick); end
  endtask

  task automatic test_nack_retry();
    int n;
    do_reset();
    nack_din  = 24'h340479;
    nack_left = 1;
    pulse_start();
    wait_done(20000, "nack_retry");
    n = 0;
    foreach (wr_log[i]) if (wr_log[i] == 24'h340479) n++;
    checks++; if (wr_log.size() != 12) begin failures++; $display("FAIL nack_count got=%0d exp=12", wr_log.size()); end
    checks++; if (n != 2) begin failures++; $display("FAIL nack_entry4_writes got=%0d exp=2", n); end
    if (wr_log.size() == 12) begin
      checks++; if (wr_log[6] !== 24'h340679) begin failures++; $display("FAIL nack_advance got=%h exp=340679", wr_log[6]); end
    end
    checks++; if (cfg_ok !== 1'b1 || cfg_err !== 1'b0) begin failures++; $display("FAIL nack_status ok/err=%b%b exp=10", cfg_ok, cfg_err); end
  endtask

  task automatic test_abort();
    int n;
    do_reset();
    nack_din  = 24'h340017;
    nack_left = -1;
    pulse_start();
    wait_done(20000, "abort");
    n = 0;
    foreach (wr_log[i]) if (wr_log[i] == 24'h340017) n++;
    checks++; if (n != 3) begin failures++; $display("FAIL abort_entry2_writes got=%0d exp=3", n); end
    checks++; if (wr_log.size() != 5) begin failures++; $display("FAIL abort_total got=%0d exp=5", wr_log.size()); end
    checks++; if (cfg_err !== 1'b1 || cfg_ok !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL abort_status err/ok/busy=%b%b%b exp=100", cfg_err, cfg_ok, busy); end
    checks++; if (err_idx !== 4'd2) begin failures++; $display("FAIL abort_err_idx got=%0d exp=2", err_idx); end
    repeat (1200) @(negedge clk);
    checks++; if (wr_log.size() != 5) begin failures++; $display("FAIL abort_quiet got=%0d exp=5", wr_log.size()); end
  endtask

  task automatic test_timeout();
    do_reset();
    no_resp = 1'b1;
    pulse_start();
    wait_done(5000, "timeout");
    checks++; if (wr_log.size() != 3) begin failures++; $display("FAIL timeout_writes got=%0d exp=3", wr_log.size()); end
    if (wr_log.size() == 3) begin
      // WAIT lasts TO cycles, then GAP cycles, then one ISSUE cycle.
      for (int i = 1; i < 3; i++) begin
        checks++; if (wr_cyc[i] - wr_cyc[i-1] != TO + GAP + 1) begin failures++; $display("FAIL timeout_spacing[%0d] got=%0d exp=%0d", i, wr_cyc[i] - wr_cyc[i-1], TO + GAP + 1); end
        checks++; if (wr_log[i] !== 24'h341E00) begin failures++; $display("FAIL timeout_din[%0d] got=%h exp=341e00", i, wr_log[i]); end
      end
    end
    checks++; if (cfg_err !== 1'b1 || err_idx !== 4'd0 || cfg_ok !== 1'b0) begin failures++; $display("FAIL timeout_status err/idx/ok=%b/%0d/%b exp=1/0/0", cfg_err, err_idx, cfg_ok); end
  endtask

  task automatic test_start_ignored();
    int r;
    int n;
    int dones;
    logic early_wr;
    do_reset();
    hold_low = 1'b1;
    pulse_start();
    early_wr = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (bus.wr_i2c === 1'b1) early_wr = 1'b1;
    end
    checks++; if (early_wr || wr_log.size() != 0) begin failures++; $display("FAIL idle_low_write got=%0d writes exp=0", wr_log.size()); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL idle_low_busy got=%b exp=1", busy); end
    @(posedge clk); #1 hold_low = 1'b0;
    r = cyc;
    n = 0;
    while (wr_log.size() < 3 && n < 5000) begin @(negedge clk); n++; end
    checks++; if (wr_cyc.size() == 0 || wr_cyc[0] != r + 1) begin failures++; $display("FAIL idle_release_wr got=%0d exp=%0d", (wr_cyc.size() > 0) ? wr_cyc[0] : -1, r + 1); end
    pulse_start();
    dones = 0;
    n = 0;
    while (n < 8000 && dones == 0) begin
      @(negedge clk);
      n++;
      if (done_tick === 1'b1) dones++;
    end
    checks++; if (wr_log.size() != 11 || cfg_ok !== 1'b1) begin failures++; $display("FAIL midrun_start writes=%0d ok=%b exp 11/1", wr_log.size(), cfg_ok); end
    repeat (700) begin
      @(negedge clk);
      if (done_tick === 1'b1) dones++;
    end
    checks++; if (wr_log.size() != 11 || dones != 1 || busy !== 1'b0) begin failures++; $display("FAIL midrun_no_rerun writes=%0d dones=%0d busy=%b exp 11/1/0", wr_log.size(), dones, busy); end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    pulse_start();
    n = 0;
    while (wr_log.size() < 7 && n < 8000) begin @(negedge clk); n++; end
    checks++; if (wr_log.size() < 7 || wr_log[6] !== 24'h340812) begin failures++; $display("FAIL reset_mid_reach writes=%0d exp entry 6 issued", wr_log.size()); end
    @(posedge clk); #1 reset = 1'b1;
    #1;
    checks++; if ({busy, done_tick, cfg_ok, cfg_err, bus.wr_i2c} !== 5'b0 || bus.din !== 24'h0 || err_idx !== 4'd0) begin
      failures++; $display("FAIL reset_mid_outputs busy/done/ok/err/wr=%b%b%b%b%b din=%h exp all 0", busy, done_tick, cfg_ok, cfg_err, bus.wr_i2c, bus.din);
    end
    repeat (2) @(posedge clk);
    #1;
    wr_log.delete();
    wr_cyc.delete();
    done_cyc.delete();
    reset = 1'b0;
    pulse_start();
    n = 0;
    while (wr_log.size() < 1 && n < 100) begin @(negedge clk); n++; end
    checks++; if (wr_log.size() < 1 || wr_log[0] !== 24'h341E00) begin failures++; $display("FAIL reset_mid_restart got=%h exp=341e00", (wr_log.size() > 0) ? wr_log[0] : 24'hx); end
  endtask

  initial begin
    test_reset();
    test_all_ack();
    test_nack_retry();
    test_abort();
    test_timeout();
    test_start_ignored();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
